// File: rtl/ram_rd_checker.sv
// ---------------------------------------------------------------------------
// ram_rd_checker
//
// Read-side verifier for the dual-port block RAM. After the writer raises
// ram_rd_flag (rising edge), the checker sweeps every address on port B,
// one per clock, and compares each returned byte against the expected
// pattern (addr + DATA_BASE) mod 2^DATA_W. The result is reported on
// busy / done / pass / error-count outputs for probes and LEDs.
//
// Optional feature macro: RAM_CHK_FIRST_ERR_EN
//   When defined, first_err_addr / first_err_data capture the address and
//   received byte of the first mismatch of each sweep.
//
// Ports:
//   clk            system clock (shared with writer and RAM)
//   rst_n          synchronous active-low reset
//   ram_rd_flag    writer level: RAM contents complete, may be read
//   ram_rd_en      RAM port B enable (enb)
//   ram_rd_addr    RAM port B address (addrb)
//   ram_rd_data    RAM port B read data (doutb), RD_LAT clocks after issue
//   chk_busy       high while a sweep is in progress
//   chk_done       one-clock pulse after the last compare of a sweep
//   chk_pass       result of last completed sweep (1 = no mismatches)
//   err_cnt        mismatch count of last/current sweep, saturating
//   first_err_addr address of first mismatch     (RAM_CHK_FIRST_ERR_EN)
//   first_err_data data of first mismatch        (RAM_CHK_FIRST_ERR_EN)
// ---------------------------------------------------------------------------
module ram_rd_checker #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,   // 1 or 2
    parameter int DATA_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_rd_flag,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              chk_busy,
    output logic              chk_done,
    output logic              chk_pass,
    output logic [ADDR_W:0]   err_cnt
`ifdef RAM_CHK_FIRST_ERR_EN
    ,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_W:0]   ERR_ONE    = 1;
    localparam logic [ADDR_W:0]   ERR_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] BASE_T     = DATA_W'(DATA_BASE);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0]        DRAIN_ONE  = 2'd1;

    logic [1:0] state_reg;
    logic       flag_reg;
    logic [1:0] drain_cnt_reg;
    logic       start;
    logic       cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_data;
    logic       mismatch;

    // Only a 0 -> 1 transition of the flag starts a sweep; the history
    // register clears on reset so a flag already high counts as an edge.
    assign start = ram_rd_flag & ~flag_reg;

    // Valid/address shift line matching the RAM read latency. It is fed by
    // the registered port-B outputs, i.e. exactly what the RAM samples.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic              v_reg;
        logic [ADDR_W-1:0] a_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst_n) v_reg <= 1'b0;
                else        v_reg <= ram_rd_en;
                a_reg <= ram_rd_addr;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n) v_reg <= 1'b0;
                else        v_reg <= g_stage[gi-1].v_reg;
                a_reg <= g_stage[gi-1].a_reg;
            end
        end
    end

    assign cmp_valid = g_stage[RD_LAT-1].v_reg;
    assign cmp_addr  = g_stage[RD_LAT-1].a_reg;
    assign exp_data  = DATA_W'(cmp_addr) + BASE_T;
    assign mismatch  = cmp_valid && (ram_rd_data != exp_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            flag_reg      <= 1'b0;
            drain_cnt_reg <= 2'd0;
            ram_rd_en     <= 1'b0;
            ram_rd_addr   <= '0;
            chk_busy      <= 1'b0;
            chk_done      <= 1'b0;
            chk_pass      <= 1'b0;
            err_cnt       <= '0;
        end else begin
            flag_reg <= ram_rd_flag;
            chk_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg   <= ST_READ;
                        ram_rd_en   <= 1'b1;
                        ram_rd_addr <= '0;
                        chk_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (ram_rd_addr == LAST_ADDR) begin
                        state_reg     <= ST_DRAIN;
                        ram_rd_en     <= 1'b0;
                        ram_rd_addr   <= '0;
                        drain_cnt_reg <= 2'd0;
                    end else begin
                        ram_rd_addr <= ram_rd_addr + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    // RD_LAT cycles cover the reads still inside the RAM.
                    if (drain_cnt_reg == DRAIN_LAST) state_reg <= ST_DONE;
                    else drain_cnt_reg <= drain_cnt_reg + DRAIN_ONE;
                end
                ST_DONE: begin
                    // err_cnt already includes the final compare here.
                    chk_done  <= 1'b1;
                    chk_pass  <= (err_cnt == '0);
                    chk_busy  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (state_reg == ST_IDLE && start) begin
                err_cnt <= '0;
            end else if (mismatch && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
        end
    end

`ifdef RAM_CHK_FIRST_ERR_EN
    logic first_seen_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_seen_reg <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            first_seen_reg <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch && !first_seen_reg) begin
            first_seen_reg <= 1'b1;
            first_err_addr <= cmp_addr;
            first_err_data <= ram_rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_ram_rd_checker
//
// Two checker instances share clock, reset and ram_rd_flag: one with
// RD_LAT=1 / DATA_BASE=0, one with RD_LAT=2 / DATA_BASE=0x10, each reading
// its own behavioural RAM. At every sweep start the expected result
// (error count, pass, done cycle, first error) is computed from the RAM
// contents and queued; a monitor pops and compares on every chk_done.
// ---------------------------------------------------------------------------
module tb_ram_rd_checker;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int N     = 64;
    localparam int LAT1  = 1;
    localparam int BASE1 = 0;
    localparam int LAT2  = 2;
    localparam int BASE2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flag = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          en1, en2, busy1, busy2, done1, done2, pass1, pass2;
    logic [AW-1:0] ad1, ad2;
    logic [DW-1:0] rd1, rd2;
    logic [AW:0]   err1, err2;
`ifdef RAM_CHK_FIRST_ERR_EN
    logic [AW-1:0] fea1, fea2;
    logic [DW-1:0] fed1, fed2;
`endif

    ram_rd_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1), .DATA_BASE(BASE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ram_rd_flag(flag),
        .ram_rd_en(en1), .ram_rd_addr(ad1), .ram_rd_data(rd1),
        .chk_busy(busy1), .chk_done(done1), .chk_pass(pass1), .err_cnt(err1)
`ifdef RAM_CHK_FIRST_ERR_EN
        , .first_err_addr(fea1), .first_err_data(fed1)
`endif
    );

    ram_rd_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT2), .DATA_BASE(BASE2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ram_rd_flag(flag),
        .ram_rd_en(en2), .ram_rd_addr(ad2), .ram_rd_data(rd2),
        .chk_busy(busy2), .chk_done(done2), .chk_pass(pass2), .err_cnt(err2)
`ifdef RAM_CHK_FIRST_ERR_EN
        , .first_err_addr(fea2), .first_err_data(fed2)
`endif
    );

    // Behavioural RAMs with one and two clocks of read latency.
    logic [7:0] mem1 [N];
    logic [7:0] mem2 [N];
    logic [7:0] r1_s1, r2_s1, r2_s2;
    always @(posedge clk) begin
        if (en1) r1_s1 <= mem1[ad1];
        if (en2) r2_s1 <= mem2[ad2];
        r2_s2 <= r2_s1;
    end
    assign rd1 = r1_s1;
    assign rd2 = r2_s2;

    typedef struct {
        int err;
        int pass;
        int done_cyc;
        int fa;
        int fd;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: count bytes differing from (a + base) mod 256. Called at
    // the negedge on which the flag rises; READ is entered one clock later
    // and chk_done follows 64 + lat + 1 clocks after that.
    function automatic exp_t model(input logic [7:0] m [N], input int base, input int lat);
        exp_t e;
        int   cnt = 0;
        e.fa = 0;
        e.fd = 0;
        for (int a = 0; a < N; a++) begin
            if (m[a] != 8'(a + base)) begin
                if (cnt == 0) begin
                    e.fa = a;
                    e.fd = int'(m[a]);
                end
                cnt++;
            end
        end
        e.err      = (cnt > N) ? N : cnt;
        e.pass     = (cnt == 0) ? 1 : 0;
        e.done_cyc = cyc + 1 + (N + lat + 1);
        return e;
    endfunction

    // Monitor: address sequence of dut1 and scoreboard check on chk_done.
    int run1 = 0, last_run1 = 0, run2 = 0, last_run2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (en1) begin
            check("rd_addr1", 32'(ad1), 32'(run1));
            run1++;
        end else if (run1 != 0) begin
            last_run1 = run1;
            run1 = 0;
        end
        if (en2) run2++;
        else if (run2 != 0) begin
            last_run2 = run2;
            run2 = 0;
        end

        if (done1) begin
            if (q1.size() == 0) fail_now("done1 unexpected");
            else begin
                e = q1.pop_front();
                check("err_cnt1", 32'(err1), 32'(e.err));
                check("pass1", 32'(pass1), 32'(e.pass));
                check("done_cyc1", 32'(cyc), 32'(e.done_cyc));
                check("busy1_at_done", 32'(busy1), 32'(0));
                check("rd_en_len1", 32'(last_run1), 32'(N));
`ifdef RAM_CHK_FIRST_ERR_EN
                check("first_err_addr1", 32'(fea1), 32'(e.fa));
                check("first_err_data1", 32'(fed1), 32'(e.fd));
`endif
                $display("sweep dut1: err=%0d pass=%0d done_cyc=%0d", err1, pass1, cyc);
            end
        end
        if (done2) begin
            if (q2.size() == 0) fail_now("done2 unexpected");
            else begin
                e = q2.pop_front();
                check("err_cnt2", 32'(err2), 32'(e.err));
                check("pass2", 32'(pass2), 32'(e.pass));
                check("done_cyc2", 32'(cyc), 32'(e.done_cyc));
                check("busy2_at_done", 32'(busy2), 32'(0));
                check("rd_en_len2", 32'(last_run2), 32'(N));
`ifdef RAM_CHK_FIRST_ERR_EN
                check("first_err_addr2", 32'(fea2), 32'(e.fa));
                check("first_err_data2", 32'(fed2), 32'(e.fd));
`endif
                $display("sweep dut2: err=%0d pass=%0d done_cyc=%0d", err2, pass2, cyc);
            end
        end
    end

    task automatic fill_clean();
        for (int a = 0; a < N; a++) begin
            mem1[a] = 8'(a + BASE1);
            mem2[a] = 8'(a + BASE2);
        end
    endtask

    task automatic start_sweep();
        flag = 1'b1;
        q1.push_back(model(mem1, BASE1, LAT1));
        q2.push_back(model(mem2, BASE2, LAT2));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (q1.size() != 0 || q2.size() != 0); i++)
            @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) begin
            fail_now("timeout waiting for chk_done");
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic sweep();
        @(negedge clk);
        start_sweep();
        wait_idle(200);
        flag = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_clean();
        repeat (3) @(negedge clk);
        check("rst_en1", 32'(en1), 32'(0));
        check("rst_addr1", 32'(ad1), 32'(0));
        check("rst_busy1", 32'(busy1), 32'(0));
        check("rst_done1", 32'(done1), 32'(0));
        check("rst_pass1", 32'(pass1), 32'(0));
        check("rst_err1", 32'(err1), 32'(0));
        check("rst_en2", 32'(en2), 32'(0));
        check("rst_err2", 32'(err2), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean RAM.
        sweep();
        check("clean_pass1", 32'(pass1), 32'(1));

        // Two corrupted bytes.
        fill_clean();
        mem1[5] = 8'hFF; mem2[5] = 8'hFF;
        mem1[63] = 8'h00; mem2[63] = 8'h00;
        sweep();
        check("two_err1", 32'(err1), 32'(2));
        check("two_pass1", 32'(pass1), 32'(0));
`ifdef RAM_CHK_FIRST_ERR_EN
        check("two_fea1", 32'(fea1), 32'(5));
        check("two_fed1", 32'(fed1), 32'(8'hFF));
`endif

        // 0xAA everywhere: only address 0xAA would match, outside dut1 range
        // except none; dut1 expects a, so 0xAA never matches... count via model.
        for (int a = 0; a < N; a++) begin
            mem1[a] = 8'hAA;
            mem2[a] = 8'hAA;
        end
        mem1[42] = 8'd42;   // leave one correct byte in dut1's RAM
        sweep();
        check("aa_err1", 32'(err1), 32'(63));

        // Every byte wrong: saturated count.
        for (int a = 0; a < N; a++) begin
            mem1[a] = ~8'(a + BASE1);
            mem2[a] = ~8'(a + BASE2);
        end
        sweep();
        check("allwrong_err1", 32'(err1), 32'(64));
        check("allwrong_err2", 32'(err2), 32'(64));

        // Flag held high 200 clocks, then a sweep with a drop/re-raise.
        fill_clean();
        @(negedge clk);
        start_sweep();
        repeat (200) @(negedge clk);
        flag = 1'b0;
        @(negedge clk);
        start_sweep();
        repeat (20) @(negedge clk);
        flag = 1'b0;
        repeat (2) @(negedge clk);
        flag = 1'b1;            // ignored: checker is busy
        wait_idle(200);
        repeat (100) @(negedge clk);
        flag = 1'b0;
        repeat (3) @(negedge clk);

        // Reset at address 30 mid-sweep, with errors already counted.
        fill_clean();
        mem1[1] = 8'h77; mem2[1] = 8'h77;
        mem1[2] = 8'h77; mem2[2] = 8'h77;
        @(negedge clk);
        start_sweep();
        for (int i = 0; i < 100 && !(en1 && ad1 == 6'd30); i++) @(negedge clk);
        if (!(en1 && ad1 == 6'd30)) fail_now("addr 30 not reached");
        check("pre_rst_err1", 32'(err1), 32'(2));
        rst_n = 1'b0;
        flag = 1'b0;
        q1.delete();
        q2.delete();
        @(negedge clk);
        check("midrst_en1", 32'(en1), 32'(0));
        check("midrst_busy1", 32'(busy1), 32'(0));
        check("midrst_err1", 32'(err1), 32'(0));
        check("midrst_en2", 32'(en2), 32'(0));
        check("midrst_busy2", 32'(busy2), 32'(0));
        check("midrst_err2", 32'(err2), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fill_clean();
        sweep();
        check("post_rst_pass1", 32'(pass1), 32'(1));

        // Randomized corruptions.
        for (int t = 0; t < 6; t++) begin
            int k;
            fill_clean();
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                int a;
                logic [7:0] v;
                a = $urandom_range(0, N - 1);
                v = 8'($urandom_range(1, 255));
                mem1[a] = mem1[a] ^ v;
                mem2[a] = mem2[a] ^ v;
            end
            sweep();
        end

        repeat (5) @(negedge clk);
        check("queues_empty", 32'(q1.size() + q2.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
